nova_pwr_seq: RTL and testbench

//  Power/clock/reset sequencer for the nova decoder power domain, clocked by clk_reg.

---
 rtl/nova_pkg.sv | 34 +++
 rtl/nova_sync2.sv | 25 ++
 rtl/nova_pwr_seq.sv | 189 ++++++++++++++++++
 tb/tb_nova_pwr_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nova_pkg.sv
// Shared definitions for the nova power sequencer: FSM state encoding,
// register word offsets, register bit positions and a byte-lane merge helper.
package nova_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SW_UP    = 3'd1,
    ST_ISO_REL  = 3'd2,
    ST_CLK_RUN  = 3'd3,
    ST_ON       = 3'd4,
    ST_RST_ASRT = 3'd5,
    ST_SW_DN    = 3'd6,
    ST_FAULT    = 3'd7
  } state_t;

  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_STATUS  = 3'd2;
  localparam logic [2:0] OFS_TIMEOUT = 3'd4;

  localparam int CTRL_SWREQ_BIT = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int STAT_ERR_BIT   = 4;
  localparam int STAT_ACK_BIT   = 5;

  localparam logic [15:0] TIMEOUT_RST = 16'h0100;

  function automatic logic [15:0] byteMerge(input logic [15:0] oldVal,
                                            input logic [15:0] newVal,
                                            input logic [1:0]  be);
    byteMerge = {be[1] ? newVal[15:8] : oldVal[15:8],
                 be[0] ? newVal[7:0]  : oldVal[7:0]};
  endfunction

endpackage

// File: rtl/nova_sync2.sv
// Two-flop synchronizer bringing the asynchronous switch-chain acknowledge
// into the clk_reg domain; clears to 0 on reset.
module nova_sync2 (
  input  logic clk_reg,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_reg or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/nova_pwr_seq.sv
// Power/clock/reset sequencer for the nova decoder domain with its CTRL/STATUS/TIMEOUT
// register file on the per_* bus; every sequencing output comes straight from a flop.
module nova_pwr_seq
  import nova_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h0198,
  parameter int          DEC_WD     = 3,
  parameter int          SETTLE_CYC = 8,
  parameter int          RST_CYC    = 4
) (
  input  logic        clk_reg,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        power_control,
  output logic        power_ack,
  output logic        sw_en,
  input  logic        sw_ack,
  output logic        iso_en,
  output logic        clk_gate_en,
  output logic        nova_reset_n,
  output logic        irq
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] RST_LAST    = 16'(RST_CYC - 1);
  localparam logic [15:0] DOWN_LAST   = 16'(RST_CYC + SETTLE_CYC - 1);

  logic              w_sel, w_wr, w_rd, w_ackSync, w_req;
  logic [DEC_WD-1:0] w_offset;
  logic              w_ctrlWr, w_statusWr, w_timeoutWr;
  logic              w_errSet, w_errNext, w_irqEnNext;
  logic [15:0]       w_rdData, w_cntNext;
  state_t            r_state, w_stateNext;
  logic [15:0]       r_cnt, r_timeout;
  logic              r_swEn, r_isoEn, r_clkGate, r_novaRstN, r_pwrAck;
  logic              w_swEnNext, w_isoEnNext, w_clkGateNext, w_novaRstNNext, w_pwrAckNext;
  logic              r_swReq, r_irqEn, r_err, r_irq;

  nova_sync2 u_ackSync (
    .clk_reg (clk_reg),
    .reset_n (reset_n),
    .i_d     (sw_ack),
    .o_q     (w_ackSync)
  );

  assign w_sel       = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign w_offset    = {per_addr[DEC_WD-2:0], 1'b0};
  assign w_wr        = w_sel & (|per_we);
  assign w_rd        = w_sel & (per_we == 2'b00);
  assign w_ctrlWr    = w_wr & (w_offset == DEC_WD'(OFS_CTRL));
  assign w_statusWr  = w_wr & (w_offset == DEC_WD'(OFS_STATUS));
  assign w_timeoutWr = w_wr & (w_offset == DEC_WD'(OFS_TIMEOUT));
  assign w_req       = power_control | r_swReq;

  // A hardware error set in the same cycle as a software clear must survive.
  assign w_errNext   = w_errSet | (r_err & ~(w_statusWr & per_we[0] & per_din[STAT_ERR_BIT]));
  assign w_irqEnNext = (w_ctrlWr & per_we[0]) ? per_din[CTRL_IRQEN_BIT] : r_irqEn;

  always_comb begin
    w_rdData = '0;
    case (w_offset)
      DEC_WD'(OFS_CTRL): begin
        w_rdData[CTRL_SWREQ_BIT] = r_swReq;
        w_rdData[CTRL_IRQEN_BIT] = r_irqEn;
      end
      DEC_WD'(OFS_STATUS): begin
        w_rdData[2:0]          = r_state;
        w_rdData[STAT_ERR_BIT] = r_err;
        w_rdData[STAT_ACK_BIT] = w_ackSync;
      end
      DEC_WD'(OFS_TIMEOUT): w_rdData = r_timeout;
      default:              w_rdData = '0;
    endcase
  end

  assign per_dout = w_rd ? w_rdData : 16'h0000;

  always_ff @(posedge clk_reg or negedge reset_n) begin
    if (!reset_n) begin
      r_swReq   <= 1'b0;
      r_irqEn   <= 1'b0;
      r_err     <= 1'b0;
      r_irq     <= 1'b0;
      r_timeout <= TIMEOUT_RST;
    end else begin
      r_err   <= w_errNext;
      r_irqEn <= w_irqEnNext;
      r_irq   <= w_errNext & w_irqEnNext;
      if (w_ctrlWr & per_we[0]) r_swReq <= per_din[CTRL_SWREQ_BIT];
      if (w_timeoutWr) r_timeout <= byteMerge(r_timeout, per_din, per_we);
    end
  end

  // Once a power-up or power-down has started it always runs to completion.
  always_comb begin
    w_stateNext    = r_state;
    w_swEnNext     = r_swEn;
    w_isoEnNext    = r_isoEn;
    w_clkGateNext  = r_clkGate;
    w_novaRstNNext = r_novaRstN;
    w_pwrAckNext   = r_pwrAck;
    w_errSet       = 1'b0;
    case (r_state)
      ST_OFF: if (w_req) begin
        w_swEnNext  = 1'b1;
        w_stateNext = ST_SW_UP;
      end
      ST_SW_UP: if (w_ackSync) begin
        w_isoEnNext = 1'b0;
        w_stateNext = ST_ISO_REL;
      end else if (r_cnt == r_timeout) begin
        w_errSet    = 1'b1;
        w_swEnNext  = 1'b0;
        w_stateNext = ST_FAULT;
      end
      ST_ISO_REL: if (r_cnt == SETTLE_LAST) begin
        w_clkGateNext = 1'b1;
        w_stateNext   = ST_CLK_RUN;
      end
      ST_CLK_RUN: if (r_cnt == RST_LAST) begin
        w_novaRstNNext = 1'b1;
        w_pwrAckNext   = 1'b1;
        w_stateNext    = ST_ON;
      end
      ST_ON: if (!w_req) begin
        w_novaRstNNext = 1'b0;
        w_pwrAckNext   = 1'b0;
        w_stateNext    = ST_RST_ASRT;
      end
      ST_RST_ASRT: begin
        if (r_cnt == RST_LAST) w_clkGateNext = 1'b0;
        if (r_cnt == DOWN_LAST) begin
          w_isoEnNext = 1'b1;
          w_swEnNext  = 1'b0;
          w_stateNext = ST_SW_DN;
        end
      end
      ST_SW_DN: if (!w_ackSync) begin
        w_stateNext = ST_OFF;
      end else if (r_cnt == r_timeout) begin
        w_errSet    = 1'b1;
        w_stateNext = ST_OFF;
      end
      ST_FAULT: if (!w_req) w_stateNext = ST_OFF;
      default: w_stateNext = ST_OFF;
    endcase
  end

  assign w_cntNext = (w_stateNext != r_state) ? 16'h0000 :
                     (r_cnt == 16'hFFFF)      ? r_cnt    : r_cnt + 16'd1;

  always_ff @(posedge clk_reg or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_OFF;
      r_cnt      <= 16'h0000;
      r_swEn     <= 1'b0;
      r_isoEn    <= 1'b1;
      r_clkGate  <= 1'b0;
      r_novaRstN <= 1'b0;
      r_pwrAck   <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_swEn     <= w_swEnNext;
      r_isoEn    <= w_isoEnNext;
      r_clkGate  <= w_clkGateNext;
      r_novaRstN <= w_novaRstNNext;
      r_pwrAck   <= w_pwrAckNext;
    end
  end

  assign sw_en        = r_swEn;
  assign iso_en       = r_isoEn;
  assign clk_gate_en  = r_clkGate;
  assign nova_reset_n = r_novaRstN;
  assign power_ack    = r_pwrAck;
  assign irq          = r_irq;

  // The nova clock may only run while the domain is powered and unclamped.
  assert property (@(posedge clk_reg) disable iff (!reset_n)
                   r_clkGate |-> (!r_isoEn && r_swEn));
  assert property (@(posedge clk_reg) disable iff (!reset_n)
                   r_novaRstN |-> r_clkGate);

endmodule

// File: tb/tb_nova_pwr_seq.sv
// Scoreboard bench for nova_pwr_seq: stimulus pushes the cycle and value of every
// expected output change and read result; a negedge monitor pops and compares them.
module tb_nova_pwr_seq;

  localparam logic [13:0] W_CTRL    = 14'h00CC;
  localparam logic [13:0] W_STATUS  = 14'h00CD;
  localparam logic [13:0] W_TIMEOUT = 14'h00CE;
  localparam logic [13:0] W_HOLE    = 14'h00CF;

  logic        clk_reg = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic        power_control = 1'b0;
  logic        sw_ack = 1'b0;
  logic        power_ack, sw_en, iso_en, clk_gate_en, nova_reset_n, irq;

  nova_pwr_seq dut (
    .clk_reg       (clk_reg),
    .reset_n       (reset_n),
    .per_addr      (per_addr),
    .per_din       (per_din),
    .per_en        (per_en),
    .per_we        (per_we),
    .per_dout      (per_dout),
    .power_control (power_control),
    .power_ack     (power_ack),
    .sw_en         (sw_en),
    .sw_ack        (sw_ack),
    .iso_en        (iso_en),
    .clk_gate_en   (clk_gate_en),
    .nova_reset_n  (nova_reset_n),
    .irq           (irq)
  );

  always #5 clk_reg = ~clk_reg;

  int cyc = 0;
  always @(posedge clk_reg) cyc++;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  ev_t         evQ[$];
  logic [15:0] rdQ[$];
  int          checks = 0;
  int          failures = 0;

  logic [15:0] ctrlM = 16'h0000;
  logic [15:0] timeoutM = 16'h0100;
  logic        errM = 1'b0;

  // Output vector order: {sw_en, iso_en, clk_gate_en, nova_reset_n, power_ack, irq}.
  function automatic logic [5:0] mkVec(input logic sw, input logic iso, input logic cg,
                                       input logic nr, input logic pa);
    return {sw, iso, cg, nr, pa, errM & ctrlM[1]};
  endfunction

  task automatic expectAt(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    evQ.push_back(e);
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk_reg);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [13:0] addr, input logic [15:0] din,
                               input logic [1:0] we);
    per_en = 1'b1;
    per_addr = addr;
    per_din = din;
    per_we = we;
    if (addr == W_CTRL && we[0]) ctrlM[1:0] = din[1:0];
    if (addr == W_TIMEOUT)
      timeoutM = {we[1] ? din[15:8] : timeoutM[15:8], we[0] ? din[7:0] : timeoutM[7:0]};
    if (addr == W_STATUS && we[0] && din[4]) errM = 1'b0;
    waitCycle(cyc + 1);
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic checkOutput(input logic [13:0] addr, input logic [15:0] expData);
    per_en = 1'b1;
    per_we = 2'b00;
    per_addr = addr;
    rdQ.push_back(expData);
    waitCycle(cyc + 1);
    per_en = 1'b0;
  endtask

  // Power-up timeline: ack seen 2 sync cycles after it rises, iso released on the
  // next edge, 8 settle cycles to clock-on, 4 clock cycles to reset release.
  task automatic upSeq(input int s, input int d, output int a);
    expectAt(s, mkVec(1, 1, 0, 0, 0));
    a = s + d + 3;
    expectAt(a, mkVec(1, 0, 0, 0, 0));
    expectAt(a + 8, mkVec(1, 0, 1, 0, 0));
    waitCycle(s + d);
    sw_ack = 1'b1;
  endtask

  task automatic downSeq(input int dEdge, input int u, input int r, output int o);
    expectAt(dEdge, mkVec(1, 0, 1, 0, 0));
    expectAt(dEdge + 4, mkVec(1, 0, 0, 0, 0));
    expectAt(dEdge + 12, mkVec(0, 1, 0, 0, 0));
    if (r != 0) begin
      waitCycle(r);
      power_control = 1'b1;
    end
    waitCycle(dEdge + 12 + u);
    sw_ack = 1'b0;
    o = dEdge + 15 + u;
  endtask

  always @(negedge clk_reg) begin
    logic [5:0] vec;
    logic [5:0] prevVec;
    ev_t        e;
    logic [15:0] expData;
    vec = {sw_en, iso_en, clk_gate_en, nova_reset_n, power_ack, irq};
    if (vec !== prevVec) begin
      checks++;
      if (evQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL outputs: unexpected change at cycle %0d to %b", cyc, vec);
      end else begin
        e = evQ.pop_front();
        if (e.cyc != cyc || e.vec !== vec) begin
          failures++;
          $display("[TB] FAIL outputs: got cycle=%0d vec=%b, required cycle=%0d vec=%b",
                   cyc, vec, e.cyc, e.vec);
        end
      end
      prevVec = vec;
    end
    if (per_en && per_we == 2'b00) begin
      checks++;
      if (rdQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL read: unexpected read at cycle %0d data=%h", cyc, per_dout);
      end else begin
        expData = rdQ.pop_front();
        if (per_dout !== expData) begin
          failures++;
          $display("[TB] FAIL read addr=%h cycle=%0d: got %h, required %h",
                   per_addr, cyc, per_dout, expData);
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  s, a, d, x, dEdge, f, r, o, u, c;
    bit  pending, early, reas;
    pending = 1'b0;
    o = 0;

    expectAt(1, 6'b010000);
    waitCycle(3);
    reset_n = 1'b1;
    waitCycle(4);
    checkOutput(W_CTRL, 16'h0000);
    checkOutput(W_STATUS, 16'h0000);
    checkOutput(W_TIMEOUT, 16'h0100);

    // Randomized power cycles via power_control, with late drops and re-requests.
    for (int it = 0; it < 10; it++) begin
      if (!pending) begin
        power_control = 1'b1;
        s = cyc + 1;
      end else begin
        s = o + 1;
      end
      d = $urandom_range(0, 6);
      upSeq(s, d, a);
      expectAt(a + 12, mkVec(1, 0, 1, 1, 1));
      early = ($urandom_range(0, 3) == 0);
      if (early) begin
        x = $urandom_range(s + d, a + 11);
        waitCycle(x);
        power_control = 1'b0;
        dEdge = a + 13;
      end
      waitCycle(a + 12);
      checkOutput(W_STATUS, 16'h0024);
      if (!early) begin
        f = a + 12 + $urandom_range(1, 5);
        waitCycle(f);
        power_control = 1'b0;
        dEdge = f + 1;
      end
      reas = (it != 9) && ($urandom_range(0, 2) == 0);
      r = reas ? dEdge + $urandom_range(1, 10) : 0;
      u = $urandom_range(0, 4);
      downSeq(dEdge, u, r, o);
      pending = reas;
      if (!reas) begin
        waitCycle(o + 1);
        checkOutput(W_STATUS, 16'h0000);
      end
    end

    // Switch-ack timeout with interrupt, then W1C and return to OFF.
    applyStimulus(W_CTRL, 16'h0002, 2'b01);
    applyStimulus(W_TIMEOUT, 16'h0010, 2'b11);
    power_control = 1'b1;
    s = cyc + 1;
    expectAt(s, mkVec(1, 1, 0, 0, 0));
    errM = 1'b1;
    expectAt(s + 17, mkVec(0, 1, 0, 0, 0));
    waitCycle(s + 18);
    checkOutput(W_STATUS, 16'h0017);
    errM = 1'b0;
    expectAt(cyc + 1, mkVec(0, 1, 0, 0, 0));
    applyStimulus(W_STATUS, 16'h0010, 2'b01);
    checkOutput(W_STATUS, 16'h0007);
    power_control = 1'b0;
    waitCycle(cyc + 2);
    checkOutput(W_STATUS, 16'h0000);

    // TIMEOUT of zero faults at once; a clear landing on the same edge loses.
    applyStimulus(W_TIMEOUT, 16'h0000, 2'b11);
    power_control = 1'b1;
    s = cyc + 1;
    expectAt(s, mkVec(1, 1, 0, 0, 0));
    waitCycle(s);
    expectAt(s + 1, 6'b010001);
    applyStimulus(W_STATUS, 16'h0010, 2'b01);
    errM = 1'b1;
    checkOutput(W_STATUS, 16'h0017);
    errM = 1'b0;
    expectAt(cyc + 1, 6'b010000);
    applyStimulus(W_STATUS, 16'h0010, 2'b01);
    power_control = 1'b0;
    applyStimulus(W_CTRL, 16'h0000, 2'b01);
    applyStimulus(W_TIMEOUT, 16'h0100, 2'b11);
    waitCycle(cyc + 1);
    checkOutput(W_STATUS, 16'h0000);

    // Byte-lane writes to TIMEOUT.
    applyStimulus(W_TIMEOUT, 16'hABCD, 2'b01);
    checkOutput(W_TIMEOUT, timeoutM);
    applyStimulus(W_TIMEOUT, 16'h5A00, 2'b10);
    checkOutput(W_TIMEOUT, timeoutM);
    applyStimulus(W_TIMEOUT, 16'h0100, 2'b11);

    // Software request path and reads outside the register set.
    c = cyc;
    applyStimulus(W_CTRL, 16'h0001, 2'b01);
    s = c + 2;
    d = $urandom_range(0, 4);
    upSeq(s, d, a);
    expectAt(a + 12, mkVec(1, 0, 1, 1, 1));
    waitCycle(a + 12);
    checkOutput(W_STATUS, 16'h0024);
    checkOutput(W_HOLE, 16'h0000);
    checkOutput(14'h0000, 16'h0000);
    checkOutput(W_CTRL, 16'h0001);
    c = cyc;
    applyStimulus(W_CTRL, 16'h0000, 2'b01);
    downSeq(c + 2, 1, 0, o);
    waitCycle(o + 1);
    checkOutput(W_STATUS, 16'h0000);

    // Asynchronous reset in the middle of CLK_RUN.
    power_control = 1'b1;
    s = cyc + 1;
    upSeq(s, 1, a);
    waitCycle(a + 10);
    reset_n = 1'b0;
    power_control = 1'b0;
    sw_ack = 1'b0;
    ctrlM = 16'h0000;
    timeoutM = 16'h0100;
    errM = 1'b0;
    expectAt(a + 10, 6'b010000);
    waitCycle(a + 13);
    reset_n = 1'b1;
    waitCycle(cyc + 1);
    checkOutput(W_STATUS, 16'h0000);
    checkOutput(W_CTRL, 16'h0000);
    checkOutput(W_TIMEOUT, 16'h0100);

    waitCycle(cyc + 5);
    checks++;
    if (evQ.size() != 0 || rdQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d output events and %0d reads still pending, required 0",
               evQ.size(), rdQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
